// File: rtl/trace_buffer_pkg.sv
// Shared types and constants for the instruction-trace ring: word-select codes,
// default depth and the 65-bit record layout.
package trace_buffer_pkg;

  localparam int TRACE_DEPTH_LOG2_DEF = 4;

  localparam logic [2:0] TRACE_W_IADDR  = 3'd0;
  localparam logic [2:0] TRACE_W_IDATA  = 3'd1;
  localparam logic [2:0] TRACE_W_AADDR  = 3'd2;
  localparam logic [2:0] TRACE_W_ADATA  = 3'd3;
  localparam logic [2:0] TRACE_W_STATUS = 3'd4;

  typedef struct packed {
    logic [15:0] iaddr;
    logic [15:0] idata;
    logic [15:0] aaddr;
    logic [15:0] adata;
    logic        avalid;
  } entry_t;

  function automatic logic [15:0] trace_word(input entry_t e, input logic [2:0] wsel);
    logic [15:0] w;
    w = 16'h0000;
    case (wsel)
      TRACE_W_IADDR:  w = e.iaddr;
      TRACE_W_IDATA:  w = e.idata;
      TRACE_W_AADDR:  w = e.aaddr;
      TRACE_W_ADATA:  w = e.adata;
      TRACE_W_STATUS: w = {15'd0, e.avalid};
      default:        w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// Snoop/control/status bundle between the debug-port logic and the trace ring.
interface trace_buffer_if #(parameter int DEPTH_LOG2 = 4);
  logic                  COMMIT;
  logic [15:0]           SNOOP_INST_ADDR;
  logic [15:0]           SNOOP_INST_DATA;
  logic [15:0]           SNOOP_ARG_ADDR;
  logic [15:0]           SNOOP_ARG_DATA;
  logic                  SNOOP_ARG_VALID;
  logic                  TRACE_EN;
  logic                  TRACE_WRAP;
  logic                  TRACE_CLEAR;
  logic                  TRACE_POP;
  logic [2:0]            TRACE_WSEL;
  logic [15:0]           TRACE_DOUT;
  logic [DEPTH_LOG2:0]   TRACE_COUNT;
  logic                  TRACE_EMPTY;
  logic                  TRACE_FULL;
  logic                  TRACE_OVERFLOW;

  modport master (
    output COMMIT, SNOOP_INST_ADDR, SNOOP_INST_DATA, SNOOP_ARG_ADDR, SNOOP_ARG_DATA,
           SNOOP_ARG_VALID, TRACE_EN, TRACE_WRAP, TRACE_CLEAR, TRACE_POP, TRACE_WSEL,
    input  TRACE_DOUT, TRACE_COUNT, TRACE_EMPTY, TRACE_FULL, TRACE_OVERFLOW
  );

  modport slave (
    input  COMMIT, SNOOP_INST_ADDR, SNOOP_INST_DATA, SNOOP_ARG_ADDR, SNOOP_ARG_DATA,
           SNOOP_ARG_VALID, TRACE_EN, TRACE_WRAP, TRACE_CLEAR, TRACE_POP, TRACE_WSEL,
    output TRACE_DOUT, TRACE_COUNT, TRACE_EMPTY, TRACE_FULL, TRACE_OVERFLOW
  );
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port record store: synchronous write, asynchronous read.
// Left without reset so it maps onto distributed RAM.
module trace_ram
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = TRACE_DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  entry_t                wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output entry_t                rdata
);

  entry_t mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Circular instruction-trace store: captures one record per committed
// instruction and drains oldest-first one 16-bit word at a time.
module trace_buffer
  import trace_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = TRACE_DEPTH_LOG2_DEF
) (
  input  logic CLK,
  input  logic RESET,
  trace_buffer_if.slave tb_if
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  commit_dly_q, commit_dly_d;
  logic [15:0]           dout_q, dout_d;

  logic   cap, empty, full, we;
  entry_t wr_entry, rd_entry;

  // ARG fields settle one cycle after COMMIT, so capture fires off the delayed strobe
  assign cap   = commit_dly_q & tb_if.TRACE_EN;
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  assign wr_entry = {tb_if.SNOOP_INST_ADDR, tb_if.SNOOP_INST_DATA,
                     tb_if.SNOOP_ARG_ADDR, tb_if.SNOOP_ARG_DATA, tb_if.SNOOP_ARG_VALID};

  trace_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (CLK),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    we           = 1'b0;
    commit_dly_d = tb_if.COMMIT;

    if (tb_if.TRACE_CLEAR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (cap && tb_if.TRACE_POP && !empty) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else if (cap && !full) begin
      // also covers CAP+POP on an empty ring: the pop has nothing to discard
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (cap && tb_if.TRACE_WRAP) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q + 1'b1;
      ovf_d    = 1'b1;
    end else if (cap) begin
      ovf_d    = 1'b1;
    end else if (tb_if.TRACE_POP && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end

    dout_d = empty ? 16'h0000 : trace_word(rd_entry, tb_if.TRACE_WSEL);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      commit_dly_q <= 1'b0;
      dout_q       <= 16'h0000;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      commit_dly_q <= commit_dly_d;
      dout_q       <= dout_d;
    end
  end

  assign tb_if.TRACE_DOUT     = dout_q;
  assign tb_if.TRACE_COUNT    = count_q;
  assign tb_if.TRACE_EMPTY    = empty;
  assign tb_if.TRACE_FULL     = full;
  assign tb_if.TRACE_OVERFLOW = ovf_q;

endmodule
